dmem_arbiter: RTL and testbench

- Shares the single data_mem port between two requesters: port 0 is the core load/store path, port 1 is an auxiliary master such as a program-data loader or test DMA.
- Arbitration is round-robin. A port that keeps requesting may hold the memory for up to MAX_BURST consecutive grants; after that it must yield if the other port is waiting.
- The block sits between the core datapath and data_mem. It drives the memory address, read and write controls, returns read data one cycle later, and gives the core a stall signal.

---
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one data_mem port between core and aux master
module dmem_arbiter #(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          rvalid0,
   output logic [DW-1:0] rdata0,
   output logic          stall0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);

   logic          r_last_gnt;
   logic          r_owner_vld;
   logic          r_owner;
   logic [3:0]    r_burst_cnt;
   logic          r_rvalid0;
   logic          r_rvalid1;
   logic [DW-1:0] r_rdata0;
   logic [DW-1:0] r_rdata1;

   logic          w_gnt0;
   logic          w_gnt1;
   logic          w_any;
   logic          w_we;
   logic          w_rd0;
   logic          w_rd1;

   // reset is active-low: while it is 0 no grant may reach the memory
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (reset) begin
         if (req0 && !req1) begin
            w_gnt0 = 1'b1;
         end else if (req1 && !req0) begin
            w_gnt1 = 1'b1;
         end else if (req0 && req1) begin
            if (r_owner_vld && (r_burst_cnt < LP_MAX_BURST)) begin
               w_gnt0 = ~r_owner;
               w_gnt1 = r_owner;
            end else begin
               w_gnt0 = r_last_gnt;
               w_gnt1 = ~r_last_gnt;
            end
         end
      end
   end

   assign w_any = w_gnt0 | w_gnt1;
   assign w_we  = (w_gnt0 & we0) | (w_gnt1 & we1);
   assign w_rd0 = w_gnt0 & ~we0;
   assign w_rd1 = w_gnt1 & ~we1;

   assign gnt0      = w_gnt0;
   assign gnt1      = w_gnt1;
   assign stall0    = reset & req0 & ~w_gnt0;
   assign mem_wr    = w_we;
   assign mem_rd    = w_any & ~w_we;
   assign mem_addr  = w_gnt0 ? addr0  : (w_gnt1 ? addr1  : '0);
   assign mem_wdata = w_gnt0 ? wdata0 : (w_gnt1 ? wdata1 : '0);

   assign rvalid0 = r_rvalid0;
   assign rvalid1 = r_rvalid1;
   assign rdata0  = r_rdata0;
   assign rdata1  = r_rdata1;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_last_gnt  <= 1'b1;
         r_owner_vld <= 1'b0;
         r_owner     <= 1'b0;
         r_burst_cnt <= 4'd0;
         r_rvalid0   <= 1'b0;
         r_rvalid1   <= 1'b0;
         r_rdata0    <= '0;
         r_rdata1    <= '0;
      end else begin
         r_rvalid0 <= w_rd0;
         r_rvalid1 <= w_rd1;
         if (w_rd0) r_rdata0 <= mem_rdata;
         if (w_rd1) r_rdata1 <= mem_rdata;

         // burst_cnt saturates so a lone requester never wraps back under the limit
         if (w_any) begin
            r_last_gnt <= w_gnt1;
            if (r_owner_vld && (r_owner == w_gnt1)) begin
               if (r_burst_cnt < LP_MAX_BURST) r_burst_cnt <= r_burst_cnt + 4'd1;
            end else begin
               r_owner_vld <= 1'b1;
               r_owner     <= w_gnt1;
               r_burst_cnt <= 4'd1;
            end
         end else begin
            r_owner_vld <= 1'b0;
            r_burst_cnt <= 4'd0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

   logic       CLK = 1'b0;
   logic       reset;
   logic       req0, we0, req1, we1;
   logic [7:0] addr0, wdata0, addr1, wdata1;
   logic       gnt0, rvalid0, stall0, gnt1, rvalid1;
   logic [7:0] rdata0, rdata1;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_rd, mem_wr;
   logic [7:0] mem [0:255];

   int vectors    = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   assign mem_rdata = mem[mem_addr];
   always @(posedge CLK) if (mem_wr) mem[mem_addr] <= mem_wdata;

   dmem_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
      .CLK(CLK), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .stall0(stall0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge CLK);
      #1;
   endtask

   int         cont_p [9]  = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
   int         alt_p  [7]  = '{0, 0, 0, 0, 1, 0, 0};
   logic       alt_r1 [7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [7:0] alt_d  [7]  = '{8'h7A, 8'h7A, 8'h7A, 8'h7A, 8'h00, 8'h3C, 8'h3C};

   initial begin
      int prev;
      int wait1;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      reset = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01; wdata0 = 8'h00;
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02; wdata1 = 8'h00;
      next_cycle;

      // held in reset with both ports requesting
      repeat (2) begin
         #1;
         chk("rst_gnt0", gnt0, 0);
         chk("rst_gnt1", gnt1, 0);
         chk("rst_stall0", stall0, 0);
         chk("rst_rvalid0", rvalid0, 0);
         chk("rst_rvalid1", rvalid1, 0);
         chk("rst_mem_wr", mem_wr, 0);
         chk("rst_mem_rd", mem_rd, 0);
         next_cycle;
      end

      // continuous contention after release: 0,0,0,0,1,1,1,1,0
      reset = 1'b1;
      prev = -1;
      for (int i = 0; i < 9; i++) begin
         #1;
         chk("cont_gnt0", gnt0, 32'(cont_p[i] == 0));
         chk("cont_gnt1", gnt1, 32'(cont_p[i] == 1));
         chk("cont_stall0", stall0, 32'(cont_p[i] == 1));
         chk("cont_mem_rd", mem_rd, 1);
         chk("cont_rvalid0", rvalid0, 32'(prev == 0));
         chk("cont_rvalid1", rvalid1, 32'(prev == 1));
         if (prev == 0) chk("cont_rdata0", rdata0, 8'h5B);
         if (prev == 1) chk("cont_rdata1", rdata1, 8'h58);
         prev = cont_p[i];
         next_cycle;
      end

      // idle gap, then port 1 alone
      req0 = 1'b0; req1 = 1'b0;
      #1;
      chk("gap_gnt0", gnt0, 0);
      chk("gap_gnt1", gnt1, 0);
      chk("gap_mem_rd", mem_rd, 0);
      chk("gap_mem_wr", mem_wr, 0);
      chk("gap_mem_addr", mem_addr, 0);
      chk("gap_rvalid0", rvalid0, 1);
      chk("gap_rdata0", rdata0, 8'h5B);
      next_cycle;
      req1 = 1'b1;
      #1;
      chk("solo_gnt1", gnt1, 1);
      chk("solo_gnt0", gnt0, 0);
      chk("solo_stall0", stall0, 0);
      chk("solo_rvalid0", rvalid0, 0);
      next_cycle;
      req1 = 1'b0;
      #1;
      chk("solo_rvalid1", rvalid1, 1);
      chk("solo_rdata1", rdata1, 8'h58);
      next_cycle;

      // port 0 write then read of 0x10
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'hA5;
      #1;
      chk("wr_gnt0", gnt0, 1);
      chk("wr_mem_wr", mem_wr, 1);
      chk("wr_mem_rd", mem_rd, 0);
      chk("wr_mem_addr", mem_addr, 8'h10);
      chk("wr_mem_wdata", mem_wdata, 8'hA5);
      chk("wr_stall0", stall0, 0);
      next_cycle;
      we0 = 1'b0;
      #1;
      chk("rd_gnt0", gnt0, 1);
      chk("rd_mem_rd", mem_rd, 1);
      chk("rd_stall0", stall0, 0);
      chk("rd_rvalid0_after_wr", rvalid0, 0);
      next_cycle;
      req0 = 1'b0;
      #1;
      chk("rd_rvalid0", rvalid0, 1);
      chk("rd_rdata0", rdata0, 8'hA5);
      chk("rd_stall0_idle", stall0, 0);
      next_cycle;
      #1;
      chk("rd_rvalid0_pulse", rvalid0, 0);
      chk("rd_rdata0_hold", rdata0, 8'hA5);
      next_cycle;

      // port 0 streams reads of 0x20 while port 1 writes 0x3C there once
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
      we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h3C;
      prev = -1;
      wait1 = 0;
      for (int i = 0; i < 7; i++) begin
         req1 = alt_r1[i];
         #1;
         chk("alt_gnt0", gnt0, 32'(alt_p[i] == 0));
         chk("alt_gnt1", gnt1, 32'(alt_p[i] == 1));
         chk("alt_stall0", stall0, 32'(alt_p[i] == 1));
         chk("alt_rvalid0", rvalid0, 32'(prev == 0));
         if (prev == 0) chk("alt_rdata0", rdata0, alt_d[i-1]);
         if (req1 && !gnt1) wait1++;
         prev = alt_p[i];
         next_cycle;
      end
      chk("alt_wait1_bound", 32'(wait1 <= 4), 1);
      req0 = 1'b0;
      #1;
      chk("alt_last_rvalid0", rvalid0, 1);
      chk("alt_last_rdata0", rdata0, 8'h3C);
      next_cycle;

      // reset lands during a port 1 read grant
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
      #1;
      chk("mid_gnt1", gnt1, 1);
      #1;
      reset = 1'b0;
      #1;
      chk("mid_gnt1_rst", gnt1, 0);
      chk("mid_rvalid1_rst", rvalid1, 0);
      chk("mid_rdata1_rst", rdata1, 0);
      next_cycle;
      #1;
      chk("mid_rvalid1_edge", rvalid1, 0);
      next_cycle;
      reset = 1'b1;
      req0 = 1'b1; addr0 = 8'h01;
      #1;
      chk("post_gnt0", gnt0, 1);
      chk("post_gnt1", gnt1, 0);
      chk("post_rvalid1", rvalid1, 0);
      chk("post_rdata1", rdata1, 0);
      next_cycle;
      req0 = 1'b0; req1 = 1'b0;
      #1;
      chk("post_rvalid0", rvalid0, 1);
      chk("post_rdata0", rdata0, 8'h5B);
      chk("post_rvalid1_idle", rvalid1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
